// File: rtl/beam_gather.sv
// beam_gather: collects one beam from the selected DAC-side channel into a FIFO
// and replays it as a framed stream of FRAME_LEN beats with backpressure.
module beam_gather #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FRAME_LEN  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        src_sel,
    input  logic [DATA_W-1:0] ch1_t_data,
    input  logic              ch1_t_valid,
    input  logic [DATA_W-1:0] ch2_t_data,
    input  logic              ch2_t_valid,
    input  logic [DATA_W-1:0] ch3_t_data,
    input  logic              ch3_t_valid,
    output logic [DATA_W-1:0] mod_t_data,
    output logic              mod_t_valid,
    input  logic              mod_t_ready,
    output logic              mod_t_last,
    output logic              frame_done,
    output logic [2:0]        ovf,
    input  logic              ovf_clr
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } state_t;

    state_t            state;
    logic [1:0]        active_sel;
    logic [CW-1:0]     in_cnt;
    logic [CW-1:0]     out_cnt;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    logic              act_valid;
    logic [DATA_W-1:0] act_data;
    logic              fifo_empty;
    logic              fifo_full;
    logic              handshake;
    logic              pop;
    logic              in_fire;
    logic              wr_en;
    logic [2:0]        ovf_set;
    logic [CW-1:0]     next_idx;

    // Route the latched channel and derive FIFO/handshake controls.
    always_comb begin
        act_valid = 1'b0;
        act_data  = '0;
        ovf_set   = 3'b000;
        unique case (active_sel)
            2'd0:    begin act_valid = ch1_t_valid; act_data = ch1_t_data; end
            2'd1:    begin act_valid = ch2_t_valid; act_data = ch2_t_data; end
            2'd2:    begin act_valid = ch3_t_valid; act_data = ch3_t_data; end
            default: begin act_valid = 1'b0;        act_data = '0;         end
        endcase

        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        handshake  = mod_t_valid && mod_t_ready;
        pop        = !fifo_empty && (!mod_t_valid || mod_t_ready);
        in_fire    = (state == FILL) && act_valid;
        // A pop in the same cycle frees a slot, so a full FIFO still takes the write.
        wr_en      = in_fire && (!fifo_full || pop);
        if (in_fire && fifo_full && !pop) begin
            ovf_set = 3'b001 << active_sel;
        end
        // Frame index of the beat about to enter the output stage.
        next_idx   = out_cnt + CW'(mod_t_valid);
    end

    // FIFO storage; contents need no reset because the pointers are flushed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= act_data;
        end
    end

    // Control FSM, FIFO pointers, output stage and overflow flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            active_sel  <= 2'd0;
            in_cnt      <= '0;
            out_cnt     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mod_t_data  <= '0;
            mod_t_valid <= 1'b0;
            mod_t_last  <= 1'b0;
            frame_done  <= 1'b0;
            ovf         <= 3'b000;
        end else begin
            frame_done <= 1'b0;
            ovf        <= (ovf & ~{3{ovf_clr}}) | ovf_set;

            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end

            if (pop) begin
                rd_ptr      <= rd_ptr + PW'(1);
                mod_t_data  <= mem[rd_ptr[AW-1:0]];
                mod_t_valid <= 1'b1;
                mod_t_last  <= (next_idx == LAST_IDX);
            end else if (handshake) begin
                mod_t_valid <= 1'b0;
                mod_t_last  <= 1'b0;
            end

            if (handshake) begin
                out_cnt <= out_cnt + CW'(1);
            end

            unique case (state)
                IDLE: begin
                    if (src_sel != 2'b11) begin
                        active_sel <= src_sel;
                        in_cnt     <= '0;
                        out_cnt    <= '0;
                        state      <= FILL;
                    end
                end
                FILL: begin
                    if (wr_en) begin
                        in_cnt <= in_cnt + CW'(1);
                        if (in_cnt == LAST_IDX) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (handshake && mod_t_last) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_beam_gather.sv
// Bench for beam_gather: queue-based reference model compared every cycle,
// plus directed frame scenarios with hand-computed expectations.
module tb_beam_gather;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned FLEN   = 1024;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        src_sel = 2'b11;
    logic [DATA_W-1:0] ch1_t_data = '0;
    logic              ch1_t_valid = 1'b0;
    logic [DATA_W-1:0] ch2_t_data = '0;
    logic              ch2_t_valid = 1'b0;
    logic [DATA_W-1:0] ch3_t_data = '0;
    logic              ch3_t_valid = 1'b0;
    logic [DATA_W-1:0] mod_t_data;
    logic              mod_t_valid;
    logic              mod_t_ready = 1'b1;
    logic              mod_t_last;
    logic              frame_done;
    logic [2:0]        ovf;
    logic              ovf_clr = 1'b0;

    always #5 clk = ~clk;

    beam_gather #(
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(DEPTH),
        .FRAME_LEN (FLEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .src_sel    (src_sel),
        .ch1_t_data (ch1_t_data),
        .ch1_t_valid(ch1_t_valid),
        .ch2_t_data (ch2_t_data),
        .ch2_t_valid(ch2_t_valid),
        .ch3_t_data (ch3_t_data),
        .ch3_t_valid(ch3_t_valid),
        .mod_t_data (mod_t_data),
        .mod_t_valid(mod_t_valid),
        .mod_t_ready(mod_t_ready),
        .mod_t_last (mod_t_last),
        .frame_done (frame_done),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: accepted samples wait in a queue tagged with the edge
    // they were taken on; a sample is visible one edge after acceptance.
    int                m_state = 0;   // 0 idle, 1 fill, 2 drain
    logic [1:0]        m_sel = 2'd0;
    int                m_in = 0;
    int                m_beat = 0;
    logic [DATA_W-1:0] q[$];
    longint            qe[$];
    longint            ecnt = 0;
    bit                e_valid = 1'b0;
    logic [DATA_W-1:0] e_data = '0;
    bit                e_last = 1'b0;
    bit                e_fd = 1'b0;
    logic [2:0]        e_ovf = 3'b000;

    always @(posedge clk) begin : model_p
        int                old_state;
        int                fcnt;
        bit                hs;
        bit                pop;
        bit                av;
        logic [DATA_W-1:0] ad;
        logic [2:0]        set;
        if (rst) begin
            q.delete();
            qe.delete();
            m_state = 0;
            m_in    = 0;
            m_beat  = 0;
            e_fd    = 1'b0;
            e_ovf   = 3'b000;
        end else begin
            hs   = e_valid && mod_t_ready;
            fcnt = q.size() - int'(e_valid);
            pop  = (fcnt > 0) && (!e_valid || mod_t_ready);
            set  = 3'b000;
            case (m_sel)
                2'd0:    begin av = ch1_t_valid; ad = ch1_t_data; end
                2'd1:    begin av = ch2_t_valid; ad = ch2_t_data; end
                default: begin av = ch3_t_valid; ad = ch3_t_data; end
            endcase
            old_state = m_state;
            if (old_state == 0 && src_sel != 2'b11) begin
                m_sel   = src_sel;
                m_in    = 0;
                m_beat  = 0;
                m_state = 1;
            end else if (old_state == 1 && av) begin
                if (fcnt == int'(DEPTH) && !pop) begin
                    set[m_sel] = 1'b1;
                end else begin
                    q.push_back(ad);
                    qe.push_back(ecnt);
                    m_in++;
                    if (m_in == int'(FLEN)) m_state = 2;
                end
            end
            e_fd = 1'b0;
            if (hs) begin
                if (m_beat == int'(FLEN) - 1) begin
                    m_state = 0;
                    e_fd    = 1'b1;
                end
                void'(q.pop_front());
                void'(qe.pop_front());
                m_beat++;
            end
            e_ovf = (e_ovf & ~{3{ovf_clr}}) | set;
        end
        e_valid = (q.size() > 0) && (qe[0] < ecnt);
        if (e_valid) e_data = q[0];
        e_last = (m_beat == int'(FLEN) - 1);
        ecnt++;
    end

    // Per-cycle comparison against the model, plus handshake bookkeeping.
    int                hs_cnt = 0;
    int                last_cnt = 0;
    int                fd_cnt = 0;
    int                mon_beat = 0;
    logic [DATA_W-1:0] first_q[$];

    always @(negedge clk) begin
        check("mod_t_valid", 64'(mod_t_valid), 64'(e_valid));
        if (e_valid && mod_t_valid) begin
            check("mod_t_data", 64'(mod_t_data), 64'(e_data));
            check("mod_t_last", 64'(mod_t_last), 64'(e_last));
        end
        check("frame_done", 64'(frame_done), 64'(e_fd));
        check("ovf", 64'(ovf), 64'(e_ovf));
        if (rst) begin
            mon_beat = 0;
        end else if (mod_t_valid && mod_t_ready) begin
            hs_cnt++;
            if (mon_beat == 0) first_q.push_back(mod_t_data);
            mon_beat++;
            if (mod_t_last) begin
                last_cnt++;
                mon_beat = 0;
            end
        end
        if (frame_done) fd_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [1:0] sel);
        src_sel = sel;
        step();
        src_sel = 2'b11;
    endtask

    task automatic idle_inputs();
        ch1_t_valid = 1'b0;
        ch2_t_valid = 1'b0;
        ch3_t_valid = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget);
        int n = 0;
        while (fd_cnt == base && n < budget) begin
            step();
            n++;
        end
        check("frame_done_seen", 64'(fd_cnt > base), 64'd1);
    endtask

    function automatic logic [DATA_W-1:0] first_of(input int idx);
        logic [DATA_W-1:0] v = '1;
        if (idx < first_q.size()) v = first_q[idx];
        return v;
    endfunction

    initial begin
        int base, hs0, l0, f0, k, n, sent;
        logic [DATA_W-1:0] fv;

        // Reset state
        repeat (2) step();
        check("rst_valid", 64'(mod_t_valid), 64'd0);
        check("rst_data", 64'(mod_t_data), 64'd0);
        check("rst_last", 64'(mod_t_last), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        rst = 1'b0;
        step();

        // Test 1: ch1 streams 0..1023 at full rate
        base = fd_cnt; hs0 = hs_cnt; l0 = last_cnt; f0 = first_q.size();
        start_frame(2'b00);
        for (int i = 0; i < int'(FLEN); i++) begin
            ch1_t_valid = 1'b1; ch1_t_data = DATA_W'(i);
            step();
        end
        idle_inputs();
        wait_done(base, 200);
        check("t1_beats", 64'(hs_cnt - hs0), 64'd1024);
        check("t1_lasts", 64'(last_cnt - l0), 64'd1);
        check("t1_first", 64'(first_of(f0)), 64'd0);
        check("t1_ovf", 64'(ovf), 64'd0);

        // Test 2: ch2 selected while ch1/ch3 send garbage
        base = fd_cnt; hs0 = hs_cnt; f0 = first_q.size();
        start_frame(2'b01);
        for (int i = 0; i < int'(FLEN); i++) begin
            ch1_t_valid = 1'b1; ch1_t_data = $urandom;
            ch3_t_valid = 1'b1; ch3_t_data = $urandom;
            ch2_t_valid = 1'b1; ch2_t_data = DATA_W'(i);
            step();
        end
        idle_inputs();
        wait_done(base, 200);
        check("t2_beats", 64'(hs_cnt - hs0), 64'd1024);
        check("t2_first", 64'(first_of(f0)), 64'd0);

        // Test 3: ch3 with a 40-cycle stall; clear during overflow must lose
        base = fd_cnt; hs0 = hs_cnt; f0 = first_q.size();
        start_frame(2'b10);
        mod_t_ready = 1'b0;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            ch3_t_valid = 1'b1; ch3_t_data = DATA_W'(k); k++;
            ovf_clr = (i == 30);
            step();
            if (i == 30) check("t3_clr_vs_set", 64'(ovf), 64'h4);
        end
        ovf_clr = 1'b0;
        check("t3_ovf_stall", 64'(ovf), 64'h4);
        mod_t_ready = 1'b1;
        n = 0;
        while (fd_cnt == base && n < 3000) begin
            ch3_t_valid = 1'b1; ch3_t_data = DATA_W'(k); k++;
            step();
            n++;
        end
        idle_inputs();
        check("t3_done", 64'(fd_cnt > base), 64'd1);
        check("t3_beats", 64'(hs_cnt - hs0), 64'd1024);
        check("t3_first", 64'(first_of(f0)), 64'd0);
        check("t3_ovf_kept", 64'(ovf), 64'h4);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("t3_ovf_clr", 64'(ovf), 64'd0);

        // Test 4: random ready and gapped input on ch1
        base = fd_cnt; hs0 = hs_cnt; l0 = last_cnt; f0 = first_q.size();
        start_frame(2'b00);
        sent = 0; n = 0;
        while (fd_cnt == base && n < 8000) begin
            mod_t_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                ch1_t_valid = 1'b1; ch1_t_data = DATA_W'(sent); sent++;
            end else begin
                ch1_t_valid = 1'b0;
            end
            step();
            n++;
        end
        idle_inputs();
        mod_t_ready = 1'b1;
        check("t4_done", 64'(fd_cnt > base), 64'd1);
        check("t4_beats", 64'(hs_cnt - hs0), 64'd1024);
        check("t4_lasts", 64'(last_cnt - l0), 64'd1);
        check("t4_first", 64'(first_of(f0)), 64'd0);

        // Test 5: reset after 300 beats, then a fresh frame
        hs0 = hs_cnt;
        start_frame(2'b00);
        k = 0; n = 0;
        while ((hs_cnt - hs0) < 300 && n < 2000) begin
            ch1_t_valid = 1'b1; ch1_t_data = DATA_W'(k); k++;
            step();
            n++;
        end
        idle_inputs();
        check("t5_300_beats", 64'(hs_cnt - hs0 >= 300), 64'd1);
        rst = 1'b1;
        step();
        check("t5_rst_valid", 64'(mod_t_valid), 64'd0);
        check("t5_rst_ovf", 64'(ovf), 64'd0);
        rst = 1'b0;
        step();
        base = fd_cnt; hs0 = hs_cnt; l0 = last_cnt; f0 = first_q.size();
        start_frame(2'b00);
        for (int i = 0; i < int'(FLEN); i++) begin
            ch1_t_valid = 1'b1; ch1_t_data = 32'h5000_0000 + DATA_W'(i);
            step();
        end
        idle_inputs();
        wait_done(base, 200);
        check("t5_beats", 64'(hs_cnt - hs0), 64'd1024);
        check("t5_lasts", 64'(last_cnt - l0), 64'd1);
        check("t5_first", 64'(first_of(f0)), 64'h5000_0000);

        // Test 6: three back-to-back frames, select moves to ch2 mid-frame
        base = fd_cnt; f0 = first_q.size();
        src_sel = 2'b00;
        k = 0; n = 0;
        while (fd_cnt < base + 3 && n < 5000) begin
            ch1_t_valid = 1'b1; ch1_t_data = 32'h1000_0000 + DATA_W'(k);
            ch2_t_valid = 1'b1; ch2_t_data = 32'h2000_0000 + DATA_W'(k);
            k++;
            if (n == 500) src_sel = 2'b01;
            if (fd_cnt >= base + 2) src_sel = 2'b11;
            step();
            n++;
        end
        idle_inputs();
        src_sel = 2'b11;
        check("t6_frames", 64'(fd_cnt - base), 64'd3);
        fv = first_of(f0);
        check("t6_frame1_ch", 64'(fv[31:28]), 64'h1);
        fv = first_of(f0 + 1);
        check("t6_frame2_ch", 64'(fv[31:28]), 64'h2);
        fv = first_of(f0 + 2);
        check("t6_frame3_ch", 64'(fv[31:28]), 64'h2);

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
